// File: rtl/bcd_disp_pkg.sv
// Shared types and segment constants for the multiplexed BCD display driver.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package bcd_disp_pkg;

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Maps an active-high pin vector onto the board polarity; callers truncate to their width.
  function automatic logic [31:0] apply_polarity(input logic [31:0] v, input logic active_low);
    return active_low ? ~v : v;
  endfunction

endpackage

// File: rtl/bcd_scan_display_if.sv
// Digit-in / display-out bundle of the scan display driver.
// The slave side is the driver; the master side feeds digits and watches the pins.
interface bcd_scan_display_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output en, digits, dp_in,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  en, digits, dp_in,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder (active-high); codes A-F show a dash.
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed 7-segment driver: snapshots the BCD digit vector once per frame
// and scans the anodes one digit at a time with a blanking gap between digits.
module bcd_scan_display
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 2500,
  parameter int GAP_CYC    = 1,
  parameter int BLANK_LZ   = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               ar,
  bcd_scan_display_if.slave  bus
);

  localparam int PRE_MAX = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
  localparam int PRE_W   = $clog2(PRE_MAX);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam logic [PRE_W-1:0] SCAN_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0] GAP_LAST  = PRE_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  state_t                  fsm, fsm_next;
  logic [IDX_W-1:0]        idx, idx_next;
  logic [PRE_W-1:0]        pre, pre_next;
  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic                    load_snap;
  logic                    wrap;
  logic                    wrapped;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [3:0]              cur_digit;
  logic [6:0]              dec_seg;
  logic [6:0]              seg_ah;
  logic                    dp_ah;
  logic [NUM_DIGITS-1:0]   an_ah;

  always_ff @(posedge clk) begin
    if (ar) begin
      fsm         <= IDLE;
      idx         <= '0;
      pre         <= '0;
      snap_digits <= '0;
      snap_dp     <= '0;
      wrapped     <= 1'b0;
    end else begin
      fsm     <= fsm_next;
      idx     <= idx_next;
      pre     <= pre_next;
      wrapped <= wrap;
      if (load_snap) begin
        snap_digits <= bus.digits;
        snap_dp     <= bus.dp_in;
      end
    end
  end

  // Snapshot reloads only when a frame starts, so mid-frame digit changes never tear.
  always_comb begin
    fsm_next  = fsm;
    idx_next  = idx;
    pre_next  = pre;
    load_snap = 1'b0;
    wrap      = 1'b0;
    if (!bus.en) begin
      fsm_next = IDLE;
      idx_next = '0;
      pre_next = '0;
    end else begin
      case (fsm)
        IDLE: begin
          fsm_next  = SHOW;
          idx_next  = '0;
          pre_next  = '0;
          load_snap = 1'b1;
        end
        SHOW: begin
          if (pre == SCAN_LAST) begin
            pre_next = '0;
            fsm_next = GAP;
          end else begin
            pre_next = pre + PRE_W'(1);
          end
        end
        GAP: begin
          if (pre == GAP_LAST) begin
            pre_next = '0;
            fsm_next = SHOW;
            if (idx == IDX_LAST) begin
              idx_next  = '0;
              load_snap = 1'b1;
              wrap      = 1'b1;
            end else begin
              idx_next = idx + IDX_W'(1);
            end
          end else begin
            pre_next = pre + PRE_W'(1);
          end
        end
        default: fsm_next = IDLE;
      endcase
    end
  end

  always_comb begin : lz_scan
    logic run;
    run      = 1'b1;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run         = run & (snap_digits[4*i +: 4] == 4'd0);
      lz_blank[i] = run && (i > 0) && (BLANK_LZ != 0);
    end
  end

  assign cur_digit = snap_digits[idx*4 +: 4];

  bcd_to_7seg u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  // A suppressed leading zero keeps its anode slot and dp, only the segments go dark.
  always_comb begin
    seg_ah = SEG_BLANK;
    dp_ah  = 1'b0;
    an_ah  = '0;
    if (fsm == SHOW) begin
      an_ah[idx] = 1'b1;
      seg_ah     = lz_blank[idx] ? SEG_BLANK : dec_seg;
      dp_ah      = snap_dp[idx];
    end
  end

  assign bus.seg        = 7'(apply_polarity(32'(seg_ah), ACTIVE_LOW != 0));
  assign bus.dp         = 1'(apply_polarity(32'(dp_ah), ACTIVE_LOW != 0));
  assign bus.an         = NUM_DIGITS'(apply_polarity(32'(an_ah), ACTIVE_LOW != 0));
  assign bus.frame_done = wrapped;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench for bcd_scan_display: per-cycle expected pin states are queued
// when stimulus is driven and popped by a monitor shortly after each rising edge.
module tb_bcd_scan_display;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  logic clk;
  logic ar;
  int   n_checks;
  int   n_errors;
  int   cycle_cnt;
  exp_t exp_q[$];

  bcd_scan_display_if #(.NUM_DIGITS(4)) bus ();

  bcd_scan_display #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (4),
    .GAP_CYC    (1),
    .BLANK_LZ   (1),
    .ACTIVE_LOW (1)
  ) dut (
    .clk (clk),
    .ar  (ar),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", tag, cycle_cnt, actual, expected);
    end
  endtask

  function automatic logic [6:0] model_seg(input logic [3:0] n);
    case (n)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  task automatic push_exp(input logic [3:0] an, input logic [6:0] seg, input logic dp, input logic fd);
    exp_t e;
    e.an  = an;
    e.seg = seg;
    e.dp  = dp;
    e.fd  = fd;
    exp_q.push_back(e);
  endtask

  task automatic push_off(input int n);
    for (int k = 0; k < n; k++) push_exp(4'hF, 7'h7F, 1'b1, 1'b0);
  endtask

  // One full frame: each digit lit 4 cycles then a 1-cycle dark gap.
  task automatic push_frame(input logic [15:0] d, input logic [3:0] p, input logic fd_first);
    for (int i = 0; i < 4; i++) begin
      logic       blank;
      logic [3:0] an_exp;
      logic [6:0] seg_exp;
      blank = (i > 0);
      for (int j = i; j < 4; j++) if (d[j*4 +: 4] != 4'd0) blank = 1'b0;
      seg_exp    = blank ? 7'h7F : ~model_seg(d[i*4 +: 4]);
      an_exp     = 4'hF;
      an_exp[i]  = 1'b0;
      for (int c = 0; c < 4; c++)
        push_exp(an_exp, seg_exp, ~p[i], (i == 0 && c == 0) ? fd_first : 1'b0);
      push_off(1);
    end
  endtask

  // Holds reset for 'hold' cycles with en high, then releases; the next edge starts a frame.
  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p, input int hold);
    @(negedge clk);
    ar         = 1'b1;
    bus.en     = 1'b1;
    bus.digits = d;
    bus.dp_in  = p;
    push_off(hold);
    repeat (hold) @(negedge clk);
    ar = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 200;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput("drain", exp_q.size(), 0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #2;
    cycle_cnt++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("an", bus.an, e.an);
      checkOutput("seg", bus.seg, e.seg);
      checkOutput("dp", bus.dp, e.dp);
      checkOutput("frame_done", bus.frame_done, e.fd);
    end
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    cycle_cnt  = 0;
    ar         = 1'b1;
    bus.en     = 1'b0;
    bus.digits = '0;
    bus.dp_in  = '0;

    $display("[TB] reset and first digit");
    applyStimulus(16'h0000, 4'h0, 2);
    push_frame(16'h0000, 4'h0, 1'b0);
    wait_drain();

    $display("[TB] scan order 1234");
    applyStimulus(16'h1234, 4'h0, 2);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] an_lit;
      logic [6:0] seg_lit;
      case (i)
        0: begin an_lit = 4'hE; seg_lit = 7'h19; end
        1: begin an_lit = 4'hD; seg_lit = 7'h30; end
        2: begin an_lit = 4'hB; seg_lit = 7'h24; end
        default: begin an_lit = 4'h7; seg_lit = 7'h79; end
      endcase
      for (int c = 0; c < 4; c++) push_exp(an_lit, seg_lit, 1'b1, 1'b0);
      push_off(1);
    end
    push_exp(4'hE, 7'h19, 1'b1, 1'b1);
    push_exp(4'hE, 7'h19, 1'b1, 1'b0);
    wait_drain();

    $display("[TB] leading zeros");
    applyStimulus(16'h0070, 4'h0, 1);
    push_frame(16'h0070, 4'h0, 1'b0);
    wait_drain();
    applyStimulus(16'h0000, 4'h0, 1);
    push_frame(16'h0000, 4'h0, 1'b0);
    wait_drain();

    $display("[TB] snapshot holds for the frame");
    applyStimulus(16'h1234, 4'h0, 1);
    push_frame(16'h1234, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] an_lit;
      logic [6:0] seg_lit;
      case (i)
        0: begin an_lit = 4'hE; seg_lit = 7'h00; end
        1: begin an_lit = 4'hD; seg_lit = 7'h78; end
        2: begin an_lit = 4'hB; seg_lit = 7'h02; end
        default: begin an_lit = 4'h7; seg_lit = 7'h12; end
      endcase
      for (int c = 0; c < 4; c++) push_exp(an_lit, seg_lit, 1'b1, (i == 0 && c == 0));
      push_off(1);
    end
    repeat (6) @(negedge clk);
    bus.digits = 16'h5678;
    wait_drain();

    $display("[TB] invalid code and decimal point");
    applyStimulus(16'h0A00, 4'b0100, 1);
    push_frame(16'h0A00, 4'b0100, 1'b0);
    wait_drain();

    $display("[TB] enable drop and restart");
    applyStimulus(16'h1234, 4'b0001, 1);
    push_exp(4'hE, 7'h19, 1'b0, 1'b0);
    push_exp(4'hE, 7'h19, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    bus.en     = 1'b0;
    bus.digits = 16'h5678;
    push_off(3);
    repeat (3) @(negedge clk);
    bus.en = 1'b1;
    push_frame(16'h5678, 4'b0001, 1'b0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
Time-multiplexed 7-segment display driver that consumes the q outputs of a chain of cascaded BCD counter digits. It sits directly downstream of the counter chain. It captures the packed digit vector once per frame, decodes one digit at a time to segment patterns, and scans the common anodes with a blanking gap between digits to suppress ghosting. Optional leading-zero suppression is included. Output is board-facing, to the display pins.

Parameters:
NUM_DIGITS, 4, number of BCD digits scanned (>=2)
SCAN_DIV, 2500, clk cycles each digit is lit (>=2)
GAP_CYC, 1, clk cycles with all anodes off between digits (>=1)
BLANK_LZ, 1, 1 = suppress leading zeros; digit 0 is never suppressed
ACTIVE_LOW, 1, 1 = seg, dp and an are active-low (common-anode board)

Ports:
clk  in  1  system clock; single clock domain
ar  in  1  reset; synchronous, active-high
en  in  1  scan enable; 0 = display dark and scanner held idle
digits  in  4*NUM_DIGITS  packed BCD; digits[3:0] = digit 0 (least significant)
dp_in  in  NUM_DIGITS  decimal point request per digit
seg  out  7  segments {g,f,e,d,c,b,a}
dp  out  1  decimal point for the lit digit
an  out  NUM_DIGITS  anode select; an[i] lights digit i
frame_done  out  1  one-cycle pulse when a full frame has been scanned

Behaviour:
- Registered state: fsm, idx, prescaler pre, snap_digits and snap_dp (snapshot).
- Outputs are decoded only from registered state. There is no combinational path from digits, dp_in or en to any output.
- FSM states and transitions:
  - IDLE: all outputs off (seg=7F, dp=1, an=all-1 when ACTIVE_LOW). If en=1: load snapshot, idx=0, pre=0, go to SHOW.
  - SHOW: an[idx] on; seg and dp show snap digit idx. pre increments each cycle. At pre==SCAN_DIV-1: pre=0, go to GAP.
  - GAP: all anodes and segments off. At pre==GAP_CYC-1, pre=0, then:
    - If idx==NUM_DIGITS-1: idx=0, reload snapshot, pulse frame_done, go to SHOW.
    - Otherwise: idx=idx+1, go to SHOW.
- Timing: each digit is lit exactly SCAN_DIV cycles. Frame length is NUM_DIGITS*(SCAN_DIV+GAP_CYC) cycles.
- frame_done is high only during the single cycle in which fsm is SHOW with idx=0 following a wrap.
- Snapshot rules: snapshot loads only on IDLE->SHOW or on frame wrap. Changes on digits mid-frame never appear until the next frame, so there is no tearing.
- Decode, shown active-high; invert all bits when ACTIVE_LOW:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes A-F display a dash (40).
- Leading-zero suppression (BLANK_LZ=1): digit i is blanked (seg off, anode still scanned) when snap digits NUM_DIGITS-1 down to i are all 0 and i>0. A blanked digit still shows its dp if requested.
- en=0 in any state: next cycle fsm=IDLE, pre=0, idx=0, outputs off, frame_done=0. Raising en again restarts at digit 0 with a fresh snapshot and a full SCAN_DIV.
- ar=1 (overrides en): identical to the en=0 effect, plus snapshot cleared to 0. Mid-frame reset takes effect at the next edge.
- Prescaler width is $clog2 of max(SCAN_DIV,GAP_CYC), with no overflow beyond the terminal count.

Decomposition:
- Shared package bcd_disp_pkg holds:
  - the fsm state enum {IDLE, SHOW, GAP};
  - the ten active-high segment constants plus SEG_DASH=7'h40 and SEG_BLANK=7'h00;
  - a polarity helper function.
- One sub-module, bcd_to_7seg: a combinational 4-bit to 7-bit decoder using the package constants, including dash for invalid codes. It is reusable elsewhere.

Test Plan (SCAN_DIV=4, GAP_CYC=1, NUM_DIGITS=4, ACTIVE_LOW=1, BLANK_LZ=1):
1. Reset: ar=1 for 2 cycles with en=1 -> an=4'hF, seg=7'h7F, dp=1, frame_done=0. After release with en=1, the first SHOW shows an=4'hE.
2. Scan order: digits=16'h1234, dp_in=0 -> the sequence is:
   - an=E with seg=19 for 4 cycles, then an=F with seg=7F for 1 cycle;
   - an=D with seg=30;
   - an=B with seg=24;
   - an=7 with seg=79.
   frame_done pulses when an returns to E, 20 cycles after the first E.
3. Leading zeros: digits=16'h0070 -> digits 3 and 2 show seg=7F while their anodes are still scanned; digit 1 shows seg=78 and digit 0 shows seg=40. digits=16'h0000 -> only digit 0 shows seg=40.
4. Snapshot: change digits from 1234 to 5678 while digit 1 is lit -> the remainder of the frame shows 2 and 1. The next frame shows 8,7,6,5, i.e. seg=00,78,02,12.
5. Invalid code and dp: digits=16'h0A00, dp_in=4'b0100 -> digit 2 shows seg=3F (dash) with dp=0. Digit 3 is blanked, digits 1 and 0 show '0'.
6. en dropped mid-digit -> the next cycle shows an=F, seg=7F. Re-raising en -> digit 0 is lit for a full 4 cycles using the digits value sampled on that edge.
